mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LATENCY, 1, cycles READ/WRITE is held per access (1..15).
REQ-002 Parameter: STARVE_LIMIT, 4, consecutive data-port grants allowed while the fetch port waits (1..15).
REQ-003 Port: CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: RST  input  1  reset, asynchronous, active-high.
REQ-005 Port: IF_REQ  input  1  instruction-fetch request (read only).
REQ-006 Port: IF_ADDR  input  26  fetch word address.
REQ-007 Port: IF_ACK  output  1  one-cycle fetch completion pulse.
REQ-008 Port: IF_RDATA  output  32  fetch read data, valid while IF_ACK=1.
REQ-009 Port: D_REQ  input  1  data-port request.
REQ-010 Port: D_WE  input  1  data-port direction: 1 write, 0 read.
REQ-011 Port: D_ADDR  input  26  data word address.
REQ-012 Port: D_WDATA  input  32  data write value.
REQ-013 Port: D_ACK  output  1  one-cycle data completion pulse.
REQ-014 Port: D_RDATA  output  32  data read value, valid while D_ACK=1 and D_WE was 0.
REQ-015 Port: ADDR  output  26  memory address.
REQ-016 Port: READ / WRITE  output  1 each  memory strobes.
REQ-017 Port: MEM_DATA_IN  output  32  write data to memory.
REQ-018 Port: MEM_DATA_OUT  input  32  read data from memory.
REQ-019 Port: BUSY  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP; encoding 2 bits.
REQ-021 IDLE: if IF_REQ or D_REQ is high at the clock edge, latch the winner's address/WE/WDATA and go to ACCESS; else stay in IDLE.
REQ-022 Winner: D wins when both ports request, unless the starvation counter equals STARVE_LIMIT, in which case IF wins.
REQ-023 Starvation counter: increments on a D grant while IF_REQ=1; clears on an IF grant or when IF_REQ=0; saturates at STARVE_LIMIT.
REQ-024 ACCESS: READ (or WRITE) asserted for exactly MEM_LATENCY cycles; ADDR and MEM_DATA_IN stay stable throughout; a 4-bit down-counter times the access.
REQ-025 READ and WRITE are never high together; both are low in IDLE and RESP.
REQ-026 On the last ACCESS cycle, capture MEM_DATA_OUT into the read-data register for reads and go to RESP.
REQ-027 RESP: pulse the winner's ACK for one cycle with RDATA driven, then return to IDLE.
REQ-028 Latency: request sampled at edge N -> ACK high during cycle N+MEM_LATENCY+1; one access per MEM_LATENCY+2 cycles.
REQ-029 Requesters hold REQ and payload stable until ACK and drop REQ on the edge ending ACK; REQ still high in IDLE is a new request.
REQ-030 REQ dropped mid-access is ignored: the access completes and ACK still pulses.
REQ-031 Non-winning RDATA output holds its previous value; ADDR holds its last value outside ACCESS.

Reset
REQ-032 RST=1 forces immediately, regardless of CLK: state IDLE, READ=WRITE=0, IF_ACK=D_ACK=0, BUSY=0, ADDR=0, MEM_DATA_IN=0, IF_RDATA=D_RDATA=0, counters=0.
REQ-033 Reset during ACCESS aborts the access without a completion pulse; the first grant is evaluated at the first edge after RST falls.

Structure
REQ-034 Address/data widths come from the shared project definition include (ADDRESS_INDEX_LIMIT, DATA_INDEX_LIMIT); FSM state encodings are added there.
REQ-035 One sub-module, mem_arb_pick: priority plus starvation-counter logic, outputs grant_if/grant_d.

Verification
REQ-036 D write only, D_ADDR=0x1000000, D_WDATA=0x5, MEM_LATENCY=1 -> WRITE high for 1 cycle at 0x1000000, D_ACK 2 cycles after the sampling edge.
REQ-037 IF read only, IF_ADDR=0x0, memory word 0x20010005 -> READ for 1 cycle, IF_ACK with IF_RDATA=0x20010005.
REQ-038 IF_REQ and D_REQ held continuously -> grant order D,D,D,D,IF,D,D,D,D,IF.
REQ-039 MEM_LATENCY=3 read -> READ high exactly 3 cycles, ACK at sample+4, BUSY high 4 cycles.
REQ-040 RST pulsed mid-ACCESS -> READ/WRITE/BUSY low before the next CLK edge, no ACK; a pending request is granted after release.
REQ-041 Protocol check on every cycle: READ&WRITE never both high, ADDR stable while a strobe is high, at most one ACK per cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: bus widths, counter widths and FSM states.
package mem_arbiter_pkg;

    // Highest bit index of a memory word address and of a data word.
    localparam int ADDRESS_INDEX_LIMIT = 25;
    localparam int DATA_INDEX_LIMIT    = 31;

    // Width of the access-latency down-counter and of the starvation counter (both 1..15).
    localparam int LAT_CNT_W    = 4;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Port selection for the memory arbiter: the data port normally wins, but the
// fetch port is forced through once it has watched STARVE_LIMIT data grants in a row.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_en,
    input  logic if_req,
    input  logic d_req,
    output logic grant_if,
    output logic grant_d
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_q;
    logic [STARVE_CNT_W-1:0] starve_d;
    logic                    if_starved;

    // Decide the winner for this edge; grants only exist while the arbiter is idle.
    always_comb begin
        if_starved = (starve_q == LIMIT);
        grant_d    = grant_en && d_req && !(if_req && if_starved);
        grant_if   = grant_en && if_req && !grant_d;
    end

    // Count data grants that happened while fetch was waiting, saturating at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!if_req || grant_if) begin
            starve_d = '0;
        end else if (grant_d && !if_starved) begin
            starve_d = starve_q + STARVE_CNT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data ports share one memory with a
// fixed-latency READ/WRITE strobe, one access at a time (IDLE -> ACCESS -> RESP).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          IF_REQ,
    input  logic [ADDRESS_INDEX_LIMIT:0]  IF_ADDR,
    output logic                          IF_ACK,
    output logic [DATA_INDEX_LIMIT:0]     IF_RDATA,
    input  logic                          D_REQ,
    input  logic                          D_WE,
    input  logic [ADDRESS_INDEX_LIMIT:0]  D_ADDR,
    input  logic [DATA_INDEX_LIMIT:0]     D_WDATA,
    output logic                          D_ACK,
    output logic [DATA_INDEX_LIMIT:0]     D_RDATA,
    output logic [ADDRESS_INDEX_LIMIT:0]  ADDR,
    output logic                          READ,
    output logic                          WRITE,
    output logic [DATA_INDEX_LIMIT:0]     MEM_DATA_IN,
    input  logic [DATA_INDEX_LIMIT:0]     MEM_DATA_OUT,
    output logic                          BUSY
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LATENCY);

    arb_state_e                   state_q, state_d;
    logic [LAT_CNT_W-1:0]         lat_cnt_q, lat_cnt_d;
    logic [ADDRESS_INDEX_LIMIT:0] addr_q, addr_d;
    logic [DATA_INDEX_LIMIT:0]    wdata_q, wdata_d;
    logic                         we_q, we_d;
    logic                         win_if_q, win_if_d;
    logic                         read_q, read_d;
    logic                         write_q, write_d;
    logic                         if_ack_q, if_ack_d;
    logic                         d_ack_q, d_ack_d;
    logic [DATA_INDEX_LIMIT:0]    if_rdata_q, if_rdata_d;
    logic [DATA_INDEX_LIMIT:0]    d_rdata_q, d_rdata_d;
    logic                         idle;
    logic                         grant_if;
    logic                         grant_d;

    assign idle = (state_q == ST_IDLE);

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk      (CLK),
        .rst      (RST),
        .grant_en (idle),
        .if_req   (IF_REQ),
        .d_req    (D_REQ),
        .grant_if (grant_if),
        .grant_d  (grant_d)
    );

    // Next-state and registered-output logic; strobes and ACKs are decided one cycle
    // ahead so every output to memory and requesters comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        win_if_d   = win_if_q;
        read_d     = read_q;
        write_d    = write_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_if || grant_d) begin
                    state_d   = ST_ACCESS;
                    lat_cnt_d = LAT_LOAD;
                    win_if_d  = grant_if;
                    we_d      = grant_d && D_WE;
                    addr_d    = grant_if ? IF_ADDR : D_ADDR;
                    if (grant_d) begin
                        wdata_d = D_WDATA;
                    end
                    read_d    = !(grant_d && D_WE);
                    write_d   = grant_d && D_WE;
                end
            end
            ST_ACCESS: begin
                lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
                if (lat_cnt_q == LAT_CNT_W'(1)) begin
                    state_d = ST_RESP;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (win_if_q) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = MEM_DATA_OUT;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = MEM_DATA_OUT;
                        end
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // Arbiter FSM state and all registered outputs; reset aborts any access in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            lat_cnt_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            win_if_q   <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            win_if_q   <= win_if_d;
            read_q     <= read_d;
            write_q    <= write_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign ADDR        = addr_q;
    assign MEM_DATA_IN = wdata_q;
    assign READ        = read_q;
    assign WRITE       = write_q;
    assign IF_ACK      = if_ack_q;
    assign D_ACK       = d_ack_q;
    assign IF_RDATA    = if_rdata_q;
    assign D_RDATA     = d_rdata_q;
    assign BUSY        = !idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;

    localparam int LAT    = 1;
    localparam int LAT3   = 3;
    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Main instance (latency 1)
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [25:0] if_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0, mem_dout = '0;
    logic        if_ack, d_ack, read_o, write_o, busy;
    logic [31:0] if_rdata, d_rdata, mem_din;
    logic [25:0] addr;

    // Second instance (latency 3)
    logic        if3_req = 1'b0, d3_req = 1'b0, d3_we = 1'b0;
    logic [25:0] if3_addr = '0, d3_addr = '0;
    logic [31:0] d3_wdata = '0, mem_dout3 = '0;
    logic        if_ack3, d_ack3, read3, write3, busy3;
    logic [31:0] if_rdata3, d_rdata3, mem_din3;
    logic [25:0] addr3;

    int checks = 0;
    int passes = 0;

    logic [31:0] mem [logic [25:0]];

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(STARVE)) u_dut (
        .CLK(clk), .RST(rst),
        .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_ACK(if_ack), .IF_RDATA(if_rdata),
        .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
        .D_ACK(d_ack), .D_RDATA(d_rdata),
        .ADDR(addr), .READ(read_o), .WRITE(write_o),
        .MEM_DATA_IN(mem_din), .MEM_DATA_OUT(mem_dout), .BUSY(busy)
    );

    mem_arbiter #(.MEM_LATENCY(LAT3), .STARVE_LIMIT(STARVE)) u_dut3 (
        .CLK(clk), .RST(rst),
        .IF_REQ(if3_req), .IF_ADDR(if3_addr), .IF_ACK(if_ack3), .IF_RDATA(if_rdata3),
        .D_REQ(d3_req), .D_WE(d3_we), .D_ADDR(d3_addr), .D_WDATA(d3_wdata),
        .D_ACK(d_ack3), .D_RDATA(d_rdata3),
        .ADDR(addr3), .READ(read3), .WRITE(write3),
        .MEM_DATA_IN(mem_din3), .MEM_DATA_OUT(mem_dout3), .BUSY(busy3)
    );

    function automatic logic [31:0] lookup(input logic [25:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hC0DE0000 ^ {6'd0, a};
    endfunction

    function automatic logic [25:0] rand_addr();
        logic [25:0] a;
        a = 26'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) a[25] = 1'b1;
        return a;
    endfunction

    // Behavioural memory: writes land while WRITE is high, read data follows ADDR.
    always @(negedge clk) begin
        if (write_o) mem[addr] = mem_din;
        mem_dout  = lookup(addr);
        mem_dout3 = lookup(addr3);
    end

    // Bus protocol monitor, every cycle.
    logic        prev_strobe = 1'b0;
    logic [25:0] prev_addr = '0;
    always @(negedge clk) begin
        checks++;
        if (read_o === 1'b1 && write_o === 1'b1) $display("FAIL proto_rw_excl: READ=%b WRITE=%b required not both 1", read_o, write_o);
        else passes++;
        checks++;
        if (if_ack === 1'b1 && d_ack === 1'b1) $display("FAIL proto_one_ack: IF_ACK=%b D_ACK=%b required at most one", if_ack, d_ack);
        else passes++;
        checks++;
        if (read3 === 1'b1 && write3 === 1'b1) $display("FAIL proto3_rw_excl: READ=%b WRITE=%b required not both 1", read3, write3);
        else passes++;
        if (prev_strobe && (read_o || write_o)) begin
            checks++;
            if (addr !== prev_addr) $display("FAIL proto_addr_stable: ADDR=%h required %h", addr, prev_addr);
            else passes++;
        end
        prev_strobe = read_o || write_o;
        prev_addr   = addr;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({read_o, write_o, if_ack, d_ack, busy} !== 5'b0) $display("FAIL reset_ctrl: got %b required 00000", {read_o, write_o, if_ack, d_ack, busy}); else passes++;
        checks++; if (addr !== 26'd0) $display("FAIL reset_addr: got %h required 0", addr); else passes++;
        checks++; if (mem_din !== 32'd0) $display("FAIL reset_mem_din: got %h required 0", mem_din); else passes++;
        checks++; if (if_rdata !== 32'd0) $display("FAIL reset_if_rdata: got %h required 0", if_rdata); else passes++;
        checks++; if (d_rdata !== 32'd0) $display("FAIL reset_d_rdata: got %h required 0", d_rdata); else passes++;
        checks++; if ({read3, write3, if_ack3, d_ack3, busy3} !== 5'b0) $display("FAIL reset3_ctrl: got %b required 00000", {read3, write3, if_ack3, d_ack3, busy3}); else passes++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_d_write();
        @(negedge clk);
        d_we = 1'b1; d_addr = 26'h1000000; d_wdata = 32'h5; d_req = 1'b1;
        @(posedge clk); #1;
        checks++; if ({write_o, read_o, busy, d_ack} !== 4'b1010) $display("FAIL dwr_access: W,R,BUSY,ACK got %b required 1010", {write_o, read_o, busy, d_ack}); else passes++;
        checks++; if (addr !== 26'h1000000) $display("FAIL dwr_addr: got %h required 1000000", addr); else passes++;
        checks++; if (mem_din !== 32'h5) $display("FAIL dwr_mem_din: got %h required 5", mem_din); else passes++;
        @(posedge clk); #1;
        checks++; if ({write_o, d_ack, if_ack} !== 3'b010) $display("FAIL dwr_ack: W,D_ACK,IF_ACK got %b required 010", {write_o, d_ack, if_ack}); else passes++;
        @(posedge clk); #1;
        d_req = 1'b0;
        checks++; if ({d_ack, busy} !== 2'b00) $display("FAIL dwr_done: D_ACK,BUSY got %b required 00", {d_ack, busy}); else passes++;
        checks++; if (addr !== 26'h1000000) $display("FAIL dwr_addr_hold: got %h required 1000000", addr); else passes++;
        checks++; if (lookup(26'h1000000) !== 32'h5) $display("FAIL dwr_mem: got %h required 5", lookup(26'h1000000)); else passes++;
        @(negedge clk);
    endtask

    task automatic test_if_read();
        @(negedge clk);
        if_addr = 26'h0; if_req = 1'b1;
        @(posedge clk); #1;
        checks++; if ({read_o, write_o} !== 2'b10) $display("FAIL ifrd_strobe: R,W got %b required 10", {read_o, write_o}); else passes++;
        checks++; if (addr !== 26'h0) $display("FAIL ifrd_addr: got %h required 0", addr); else passes++;
        @(posedge clk); #1;
        checks++; if ({read_o, if_ack, d_ack} !== 3'b010) $display("FAIL ifrd_ack: R,IF_ACK,D_ACK got %b required 010", {read_o, if_ack, d_ack}); else passes++;
        checks++; if (if_rdata !== 32'h20010005) $display("FAIL ifrd_data: got %h required 20010005", if_rdata); else passes++;
        checks++; if (d_rdata !== 32'h0) $display("FAIL ifrd_d_rdata_hold: got %h required 0", d_rdata); else passes++;
        @(posedge clk); #1;
        if_req = 1'b0;
        checks++; if (if_ack !== 1'b0) $display("FAIL ifrd_ack_pulse: got %b required 0", if_ack); else passes++;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        logic order [$];
        @(negedge clk);
        if_addr = 26'h3; d_addr = 26'h4; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 10 * (LAT + 2) + 10 && order.size() < 10; c++) begin
            @(posedge clk); #1;
            if (if_ack) order.push_back(1'b1);
            if (d_ack) order.push_back(1'b0);
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        checks++;
        if (order.size() != 10) $display("FAIL starve_count: got %0d grants required 10", order.size());
        else passes++;
        for (int k = 0; k < order.size(); k++) begin
            checks++;
            if (order[k] !== ((k % (STARVE + 1)) == STARVE)) $display("FAIL starve_order[%0d]: got %s required %s", k, order[k] ? "IF" : "D", ((k % (STARVE + 1)) == STARVE) ? "IF" : "D");
            else passes++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_latency3();
        int reads = 0, busys = 0, acks = 0, ack_k = -1;
        logic [31:0] cap = '0;
        @(negedge clk);
        d3_we = 1'b0; d3_addr = 26'h5; d3_req = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == 0) d3_req = 1'b0;   // dropped mid-access: must still complete
            reads += int'(read3);
            busys += int'(busy3);
            if (d_ack3) begin acks++; ack_k = k; cap = d_rdata3; end
        end
        checks++; if (reads != LAT3) $display("FAIL lat3_read_cycles: got %0d required %0d", reads, LAT3); else passes++;
        checks++; if (busys != LAT3 + 1) $display("FAIL lat3_busy_cycles: got %0d required %0d", busys, LAT3 + 1); else passes++;
        checks++; if (acks != 1) $display("FAIL lat3_ack_count: got %0d required 1", acks); else passes++;
        checks++; if (ack_k != LAT3) $display("FAIL lat3_ack_edge: got %0d required %0d", ack_k, LAT3); else passes++;
        checks++; if (cap !== lookup(26'h5)) $display("FAIL lat3_rdata: got %h required %h", cap, lookup(26'h5)); else passes++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int ack_k = -1;
        logic [31:0] cap = '0;
        @(negedge clk);
        if3_addr = 26'h7; if3_req = 1'b1;
        @(posedge clk); #3;
        checks++; if (read3 !== 1'b1) $display("FAIL rstmid_started: READ got %b required 1", read3); else passes++;
        rst = 1'b1;
        #1;
        checks++; if ({read3, write3, busy3} !== 3'b000) $display("FAIL rstmid_async: R,W,BUSY got %b required 000", {read3, write3, busy3}); else passes++;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if ({if_ack3, busy3} !== 2'b00) $display("FAIL rstmid_hold: IF_ACK,BUSY got %b required 00", {if_ack3, busy3}); else passes++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if ({read3, busy3} !== 2'b11) $display("FAIL rstmid_regrant: R,BUSY got %b required 11", {read3, busy3}); else passes++;
        checks++; if (addr3 !== 26'h7) $display("FAIL rstmid_addr: got %h required 7", addr3); else passes++;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (if_ack3) begin
                if (ack_k < 0) ack_k = k;
                cap = if_rdata3;
                if3_req = 1'b0;
            end
        end
        if3_req = 1'b0;
        checks++; if (ack_k != LAT3) $display("FAIL rstmid_ack_edge: got %0d required %0d", ack_k, LAT3); else passes++;
        checks++; if (cap !== lookup(26'h7)) $display("FAIL rstmid_rdata: got %h required %h", cap, lookup(26'h7)); else passes++;
        @(negedge clk);
    endtask

    task automatic test_random(input int n_cycles);
        int g_last = -100, free_at = 0, starve = 0, exp_if_e = -1, exp_d_e = -1;
        logic g_read = 1'b0, g_write = 1'b0, exp_d_we = 1'b0, win_d, saw_if = 1'b0, saw_d = 1'b0;
        logic e_ack, e_busy, e_rd, e_wr;
        logic [25:0] g_addr = '0, exp_d_addr = '0;
        logic [31:0] exp_if_data = '0, exp_d_data = '0, exp_d_wdata = '0, last_if = '0, last_d = '0;
        if_req = 1'b0; d_req = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < n_cycles; e++) begin
            @(posedge clk);
            // Reference arbitration at this edge, using the inputs the DUT sees.
            if (e >= free_at && (if_req || d_req)) begin
                win_d   = d_req && !(if_req && starve == STARVE);
                g_last  = e;
                free_at = e + LAT + 2;
                if (win_d) begin
                    g_addr = d_addr; g_read = !d_we; g_write = d_we;
                    exp_d_e = e + LAT; exp_d_we = d_we; exp_d_addr = d_addr;
                    exp_d_wdata = d_wdata; exp_d_data = lookup(d_addr);
                end else begin
                    g_addr = if_addr; g_read = 1'b1; g_write = 1'b0;
                    exp_if_e = e + LAT; exp_if_data = lookup(if_addr);
                end
                if (!if_req || !win_d) starve = 0;
                else if (starve < STARVE) starve++;
            end else if (!if_req) begin
                starve = 0;
            end
            #1;
            if (saw_if || !if_req) begin
                if_req = ($urandom_range(0, 1) == 0);
                if_addr = rand_addr();
            end
            if (saw_d || !d_req) begin
                d_req = ($urandom_range(0, 2) != 0);
                d_we = ($urandom_range(0, 1) == 1);
                d_addr = rand_addr();
                d_wdata = $urandom;
            end
            @(negedge clk);
            e_ack = (exp_if_e == e);
            if (e_ack) last_if = exp_if_data;
            checks++; if (if_ack !== e_ack) $display("FAIL rnd_if_ack e=%0d: got %b required %b", e, if_ack, e_ack); else passes++;
            checks++; if (if_rdata !== last_if) $display("FAIL rnd_if_rdata e=%0d: got %h required %h", e, if_rdata, last_if); else passes++;
            e_ack = (exp_d_e == e);
            if (e_ack && !exp_d_we) last_d = exp_d_data;
            checks++; if (d_ack !== e_ack) $display("FAIL rnd_d_ack e=%0d: got %b required %b", e, d_ack, e_ack); else passes++;
            checks++; if (d_rdata !== last_d) $display("FAIL rnd_d_rdata e=%0d: got %h required %h", e, d_rdata, last_d); else passes++;
            if (e_ack && exp_d_we) begin
                checks++; if (lookup(exp_d_addr) !== exp_d_wdata) $display("FAIL rnd_mem_write e=%0d: got %h required %h", e, lookup(exp_d_addr), exp_d_wdata); else passes++;
            end
            e_busy = (e >= g_last) && (e <= g_last + LAT);
            e_rd   = (e >= g_last) && (e < g_last + LAT) && g_read;
            e_wr   = (e >= g_last) && (e < g_last + LAT) && g_write;
            checks++; if ({busy, read_o, write_o} !== {e_busy, e_rd, e_wr}) $display("FAIL rnd_busy_strobes e=%0d: got %b required %b", e, {busy, read_o, write_o}, {e_busy, e_rd, e_wr}); else passes++;
            if (e_rd || e_wr) begin
                checks++; if (addr !== g_addr) $display("FAIL rnd_addr e=%0d: got %h required %h", e, addr, g_addr); else passes++;
            end
            saw_if = if_ack;
            saw_d  = d_ack;
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (LAT + 3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[26'h0] = 32'h20010005;
        test_reset();
        test_d_write();
        test_if_read();
        test_starvation();
        test_latency3();
        test_reset_mid_access();
        test_random(600);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
